// File: rtl/mul_div_unit_if.sv
// Request/response bundle of the iterative multiply/divide unit:
// operation request, flush, HI/LO moves, status and architectural HI/LO.
interface mul_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             write_hi;
   logic             write_lo;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, flush, write_hi, write_lo, wdata,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b, flush, write_hi, write_lo, wdata,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: one bit per cycle on
// operand magnitudes, sign fix-up in a final cycle, fixed WIDTH+2 edge latency.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst,
   mul_div_unit_if.slave bus
);
   localparam int unsigned W  = WIDTH;
   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t         state;
   state_t         state_nx;
   logic           load;
   logic           step;
   logic           commit;

   logic [1:0]     op_q;
   logic           neg_a;
   logic           neg_b;
   logic           b_zero;
   logic [W-1:0]   a_q;
   logic [W-1:0]   mcand;
   logic [W-1:0]   p_hi;
   logic [W-1:0]   p_lo;
   logic [CW-1:0]  count;

   logic           is_div;
   logic           is_sgn;
   logic           a_neg_in;
   logic           b_neg_in;
   logic [W-1:0]   a_mag_in;
   logic [W-1:0]   b_mag_in;
   logic [W:0]     mul_top;
   logic [W:0]     shifted;
   logic           fits;
   logic [W-1:0]   diff;
   logic [2*W-1:0] prod;
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   quot_fix;
   logic [W-1:0]   rem_fix;
   logic [W-1:0]   res_hi;
   logic [W-1:0]   res_lo;

   assign is_div = op_q[1];
   assign is_sgn = op_q[0];

   // Operand magnitudes taken at acceptance; signed ops only look at the MSB.
   assign a_neg_in = bus.op[0] & bus.a[W-1];
   assign b_neg_in = bus.op[0] & bus.b[W-1];
   assign a_mag_in = a_neg_in ? W'(-bus.a) : bus.a;
   assign b_mag_in = b_neg_in ? W'(-bus.b) : bus.b;

   // Shift-add step: {carry, p_hi, p_lo} shifts right by one each cycle.
   assign mul_top = p_lo[0] ? ({1'b0, p_hi} + {1'b0, mcand}) : {1'b0, p_hi};

   // Restoring step: remainder in p_hi, dividend shifts out / quotient shifts in via p_lo.
   assign shifted = {p_hi, p_lo[W-1]};
   assign fits    = shifted >= {1'b0, mcand};
   assign diff    = shifted[W-1:0] - mcand;

   assign prod     = {p_hi, p_lo};
   assign prod_fix = (is_sgn && (neg_a ^ neg_b)) ? -prod : prod;
   assign quot_fix = (is_sgn && (neg_a ^ neg_b)) ? -p_lo : p_lo;
   assign rem_fix  = (is_sgn && neg_a) ? -p_hi : p_hi;

   always_comb begin
      res_hi = prod_fix[2*W-1:W];
      res_lo = prod_fix[W-1:0];
      if (is_div) begin
         if (b_zero) begin
            res_hi = a_q;
            res_lo = '1;
         end else begin
            res_hi = rem_fix;
            res_lo = quot_fix;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      step     = 1'b0;
      commit   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && !bus.flush) begin
               state_nx = RUN;
               load     = 1'b1;
            end
         end
         RUN: begin
            if (bus.flush) begin
               state_nx = IDLE;
            end else begin
               step = 1'b1;
               if (count == LAST) state_nx = FIX;
            end
         end
         FIX: begin
            state_nx = IDLE;
            commit   = !bus.flush;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Datapath, HI/LO and registered status.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q            <= '0;
         neg_a           <= 1'b0;
         neg_b           <= 1'b0;
         b_zero          <= 1'b0;
         a_q             <= '0;
         mcand           <= '0;
         p_hi            <= '0;
         p_lo            <= '0;
         count           <= '0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.div_by_zero <= 1'b0;
         bus.hi          <= '0;
         bus.lo          <= '0;
      end else begin
         bus.busy        <= (state_nx != IDLE);
         bus.done        <= commit;
         bus.div_by_zero <= commit & is_div & b_zero;

         if (load) begin
            op_q   <= bus.op;
            neg_a  <= a_neg_in;
            neg_b  <= b_neg_in;
            b_zero <= (bus.b == '0);
            a_q    <= bus.a;
            mcand  <= bus.op[1] ? b_mag_in : a_mag_in;
            p_lo   <= bus.op[1] ? a_mag_in : b_mag_in;
            p_hi   <= '0;
            count  <= '0;
         end else if (step) begin
            count <= count + CW'(1);
            if (is_div) begin
               p_hi <= fits ? diff : shifted[W-1:0];
               p_lo <= {p_lo[W-2:0], fits};
            end else begin
               p_hi <= mul_top[W:1];
               p_lo <= {mul_top[0], p_lo[W-1:1]};
            end
         end

         if (commit) begin
            bus.hi <= res_hi;
            bus.lo <= res_lo;
         end else if (state == IDLE) begin
            if (bus.write_hi) bus.hi <= bus.wdata;
            if (bus.write_lo) bus.lo <= bus.wdata;
         end
      end
   end
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit against a plain-arithmetic
// reference model of HI/LO results, latency, flush, moves and reset.
module tb_mul_div_unit;
   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mul_div_unit_if #(.WIDTH(W)) bus ();

   mul_div_unit #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: full product, or truncating quotient/remainder, b==0 special case.
   task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] eh, output logic [W-1:0] el, output logic ez);
      logic [2*W-1:0] u;
      longint         sa, sb, r, q, rm;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ez = 1'b0;
      eh = '0;
      el = '0;
      case (op)
         2'b00: begin
            u  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            eh = u[2*W-1:W];
            el = u[W-1:0];
         end
         2'b01: begin
            r  = sa * sb;
            eh = r[2*W-1:W];
            el = r[W-1:0];
         end
         default: begin
            if (b == '0) begin
               ez = 1'b1;
               eh = a;
               el = '1;
            end else if (op == 2'b10) begin
               eh = a % b;
               el = a / b;
            end else begin
               q  = sa / sb;
               rm = sa % sb;
               eh = rm[W-1:0];
               el = q[W-1:0];
            end
         end
      endcase
   endtask

   task automatic quiet(input int cycles, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
      end
      chk(tag, 64'(seen), 64'd0);
   endtask

   // Launch one op, follow it to done; the next call starts on the very next edge.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag);
      logic [W-1:0] eh, el;
      logic         ez;
      int           n;
      bit           seen, run_ok;
      model(op, a, b, eh, el, ez);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      tick();
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      bus.op    = 2'($urandom);
      chk({tag, " done_low_after_start"}, 64'(bus.done), 64'd0);
      n      = 1;
      seen   = 1'b0;
      run_ok = (bus.busy === 1'b1);
      while (!seen && n < int'(W) + 10) begin
         tick();
         n++;
         if (bus.done === 1'b1) seen = 1'b1;
         else if (bus.busy !== 1'b1 || bus.div_by_zero !== 1'b0) run_ok = 1'b0;
      end
      chk({tag, " busy_in_run"}, 64'(run_ok), 64'd1);
      chk({tag, " latency"}, 64'(n), 64'(W + 2));
      chk({tag, " hi"}, 64'(bus.hi), 64'(eh));
      chk({tag, " lo"}, 64'(bus.lo), 64'(el));
      chk({tag, " dz"}, 64'(bus.div_by_zero), 64'(ez));
      chk({tag, " busy_after"}, 64'(bus.busy), 64'd0);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 9))
         0:       return '0;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return W'($urandom_range(0, 15));
         6:       return W'(-$urandom_range(1, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [W-1:0] prev_hi, prev_lo;
      int           n;
      bit           seen;

      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.op       = 2'b00;
      bus.a        = '0;
      bus.b        = '0;
      bus.flush    = 1'b0;
      bus.write_hi = 1'b0;
      bus.write_lo = 1'b0;
      bus.wdata    = '0;
      #2 rst = 1'b0;
      #1;
      chk("reset hi", 64'(bus.hi), 64'd0);
      chk("reset lo", 64'(bus.lo), 64'd0);
      chk("reset busy", 64'(bus.busy), 64'd0);
      chk("reset done", 64'(bus.done), 64'd0);
      chk("reset dz", 64'(bus.div_by_zero), 64'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // Directed arithmetic corners, issued back to back.
      run_op(2'b01, 32'hFFFF_FFFD, 32'd7, "mult_m3x7");
      chk("mult_m3x7 hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
      chk("mult_m3x7 lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFEB);
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, "div_m7d2");
      run_op(2'b10, 32'd7, 32'd2, "divu_7d2");
      chk("divu_7d2 lo_const", 64'(bus.lo), 64'd3);
      run_op(2'b10, 32'h0000_1234, 32'd0, "divu_by0");
      run_op(2'b11, 32'hFFFF_FFF9, 32'd0, "div_by0");
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg");
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      run_op(2'b01, 32'h8000_0000, 32'h8000_0000, "mult_minneg");
      tick();
      chk("done one_cycle", 64'(bus.done), 64'd0);

      // Both moves at once.
      bus.write_hi = 1'b1;
      bus.write_lo = 1'b1;
      bus.wdata    = 32'h1111_2222;
      tick();
      bus.write_hi = 1'b0;
      bus.write_lo = 1'b0;
      chk("mov both hi", 64'(bus.hi), 64'h1111_2222);
      chk("mov both lo", 64'(bus.lo), 64'h1111_2222);

      // Flush on edge 10 with a move attempted while busy.
      bus.start = 1'b1;
      bus.op    = 2'b00;
      bus.a     = 32'd5;
      bus.b     = 32'd6;
      tick();
      bus.start = 1'b0;
      for (int i = 2; i < 10; i++) tick();
      bus.flush    = 1'b1;
      bus.write_hi = 1'b1;
      bus.wdata    = 32'hA5A5_A5A5;
      tick();
      bus.flush    = 1'b0;
      bus.write_hi = 1'b0;
      chk("flush busy", 64'(bus.busy), 64'd0);
      chk("flush hi", 64'(bus.hi), 64'h1111_2222);
      chk("flush lo", 64'(bus.lo), 64'h1111_2222);
      quiet(40, "flush no_done");

      // Start together with flush in IDLE is ignored.
      bus.start = 1'b1;
      bus.flush = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.flush = 1'b0;
      chk("start_flush busy", 64'(bus.busy), 64'd0);
      quiet(40, "start_flush no_done");

      // Move in IDLE.
      bus.write_hi = 1'b1;
      bus.wdata    = 32'hA5A5_A5A5;
      tick();
      bus.write_hi = 1'b0;
      chk("mov idle hi", 64'(bus.hi), 64'hA5A5_A5A5);
      chk("mov idle lo", 64'(bus.lo), 64'h1111_2222);

      // Move in the accepting cycle lands, then the result overwrites it.
      bus.start    = 1'b1;
      bus.op       = 2'b00;
      bus.a        = 32'd3;
      bus.b        = 32'd4;
      bus.write_lo = 1'b1;
      bus.wdata    = 32'h0000_5555;
      tick();
      bus.start    = 1'b0;
      bus.write_lo = 1'b0;
      chk("mov_start lo", 64'(bus.lo), 64'h5555);
      n    = 1;
      seen = 1'b0;
      while (!seen && n < 50) begin
         tick();
         n++;
         if (bus.done === 1'b1) seen = 1'b1;
      end
      chk("mov_start latency", 64'(n), 64'(W + 2));
      chk("mov_start lo_result", 64'(bus.lo), 64'd12);
      chk("mov_start hi_result", 64'(bus.hi), 64'd0);

      // Reset in the middle of a divide.
      tick();
      bus.write_hi = 1'b1;
      bus.write_lo = 1'b1;
      bus.wdata    = 32'hDEAD_BEEF;
      tick();
      bus.write_hi = 1'b0;
      bus.write_lo = 1'b0;
      bus.start    = 1'b1;
      bus.op       = 2'b11;
      bus.a        = W'(-100);
      bus.b        = 32'd7;
      tick();
      bus.start = 1'b0;
      for (int i = 2; i < 20; i++) tick();
      #2 rst = 1'b0;
      #1;
      chk("rst_mid hi", 64'(bus.hi), 64'd0);
      chk("rst_mid lo", 64'(bus.lo), 64'd0);
      chk("rst_mid busy", 64'(bus.busy), 64'd0);
      chk("rst_mid done", 64'(bus.done), 64'd0);
      tick();
      tick();
      rst = 1'b1;
      quiet(40, "rst_mid no_done");
      run_op(2'b11, W'(-100), 32'd7, "after_rst div");

      // Randomized ops, back to back.
      for (int k = 0; k < 40; k++) begin
         run_op(2'($urandom), pick(), pick(), $sformatf("rand%0d", k));
      end
      tick();
      chk("final done_low", 64'(bus.done), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width; legal values are WIDTH >= 4.
REQ-002 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port `clk`: input, 1 bit; rising-edge clock for all state.
REQ-004 Port `rst`: input, 1 bit; asynchronous reset, active-low.
REQ-005 Port `start`: input, 1 bit; request to begin an operation.
REQ-006 Port `op`: input, 2 bits; 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 Ports `a` and `b`: input, WIDTH bits each; `a` is the multiplicand or dividend, `b` is the multiplier or divisor.
REQ-008 Port `flush`: input, 1 bit; aborts any in-flight operation.
REQ-009 Ports `write_hi` and `write_lo`: input, 1 bit each; direct HI/LO writes (MTHI/MTLO).
REQ-010 Port `wdata`: input, WIDTH bits; data for HI/LO writes.
REQ-011 Port `busy`: output, 1 bit; an operation is in flight, and the pipeline stalls on it.
REQ-012 Port `done`: output, 1 bit; one-cycle completion pulse.
REQ-013 Port `div_by_zero`: output, 1 bit; qualifies `done` for a divide with b==0.
REQ-014 Ports `hi` and `lo`: output, WIDTH bits each; architectural HI/LO registers.

Function
REQ-015 FSM states SHALL be IDLE, RUN and FIX; `busy` SHALL be 1 exactly in RUN and FIX.
REQ-016 Start acceptance:
- In IDLE with start=1 and flush=0, the rising edge SHALL latch op, a and b, clear the iteration counter, and enter RUN.
- `start` in RUN or FIX SHALL be ignored.
REQ-017 RUN SHALL perform one iteration per cycle, for exactly WIDTH cycles, then enter FIX.
- Multiply: shift-add on the operand magnitudes.
- Divide: restoring, one quotient bit per cycle, on the operand magnitudes.
REQ-018 FIX SHALL apply sign correction, write hi/lo, pulse `done` for one cycle, and return to IDLE, all on a single edge.
REQ-019 Latency: hi, lo, done and div_by_zero SHALL update on the (WIDTH+2)th rising edge, counting the edge that samples `start` as edge 1. This is edge 34 for WIDTH=32. Latency is independent of operand values.
REQ-020 MULTU/MULT result: {hi,lo} = the full 2*WIDTH-bit product, unsigned or two's-complement respectively.
REQ-021 DIVU/DIV result:
- lo = quotient, hi = remainder.
- DIV quotient is truncated toward zero, quotient sign = sign(a) XOR sign(b), remainder sign = sign(a).
REQ-022 DIV with a = most-negative and b = -1 SHALL produce lo = most-negative and hi = 0, with no flag.
REQ-023 Divide with b==0 (either op):
- SHALL take full latency.
- SHALL produce lo = all ones and hi = a.
- SHALL assert div_by_zero together with done.
REQ-024 div_by_zero SHALL be 0 whenever done is 0.
REQ-025 flush=1 in RUN or FIX SHALL return to IDLE on the next edge: hi/lo unchanged, no done pulse, busy=0 the following cycle.
REQ-026 flush and start together in IDLE: flush wins, and start is ignored.
REQ-027 HI/LO writes:
- write_hi / write_lo SHALL load wdata into hi / lo on the edge, only when the state is IDLE.
- They SHALL be ignored while busy.
- Both asserted SHALL write both registers.
REQ-028 A write in the same IDLE cycle as an accepted start SHALL take effect; the operation result later overwrites it.
REQ-029 Back-to-back: a start presented in the cycle after done SHALL be accepted; zero idle cycles are required between operations.

Reset
REQ-030 rst low SHALL immediately force, asynchronously:
- state IDLE;
- busy = 0, done = 0, div_by_zero = 0;
- hi = 0, lo = 0;
- counter and operand/partial registers = 0.
REQ-031 Reset asserted mid-operation SHALL discard the operation, with no done pulse after release.
REQ-032 Operation SHALL resume on the first rising edge with rst high.

Verification
REQ-033 MULT, WIDTH=32, a=-3 (0xFFFFFFFD), b=7 -> on edge 34: hi=0xFFFFFFFF, lo=0xFFFFFFEB, done=1 for one cycle; busy=1 on edges 2..33.
REQ-034 DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-035 DIVU a=0x1234, b=0 -> on edge 34: lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1, done=1.
REQ-036 Start MULTU, then flush on edge 10 -> busy=0 from edge 11, hi/lo retain their prior values, no done pulse; a start together with flush in IDLE is ignored.
REQ-037 write_hi=1 with wdata=0xA5A5A5A5 while busy -> hi unchanged; the same write in IDLE -> hi=0xA5A5A5A5 next edge.
REQ-038 rst low at edge 20 of a DIV -> outputs zero immediately; no done after release; a new start after release completes normally.
